ysyx_22051013_pipe_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB regs).

---
 rtl/ysyx_22051013_pipe_ctrl_pkg.sv | 32 +++
 rtl/ysyx_22051013_ldu_detect.sv | 25 ++
 rtl/ysyx_22051013_pipe_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_22051013_pipe_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051013_pipe_ctrl_pkg.sv
// Shared types and sizes for the pipeline stall/flush sequencer.
// Imported by the top and the load-use detector.
package ysyx_22051013_pipe_ctrl_pkg;

    localparam int PCTL_OST_MAX = 2;
    localparam int PCTL_PC_W    = 64;
    localparam int PCTL_REG_W   = 5;

    // Winning pipeline event for the current cycle
    typedef enum logic [2:0] {
        EV_NONE,
        EV_TRAP,
        EV_MEM,
        EV_EX,
        EV_REDIR,
        EV_LDU,
        EV_EMPTY
    } pctl_evt_e;

    // Per-register stall/flush bundle
    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic exmem_flush;
        logic memwb_flush;
    } pctl_ctrl_t;

endpackage

// File: rtl/ysyx_22051013_ldu_detect.sv
// Load-use hazard compare between the ID sources and the EX load.
// Purely combinational; x0 never creates a hazard.
module ysyx_22051013_ldu_detect
    import ysyx_22051013_pipe_ctrl_pkg::*;
(
    input  logic [PCTL_REG_W-1:0] id_rs1,
    input  logic [PCTL_REG_W-1:0] id_rs2,
    input  logic                  id_rs1_en,
    input  logic                  id_rs2_en,
    input  logic [PCTL_REG_W-1:0] ex_rd,
    input  logic                  ex_wen,
    input  logic                  ex_is_load,
    output logic                  ld_use
);

    logic ld_wr;
    logic rs1_hit;
    logic rs2_hit;

    assign ld_wr   = ex_is_load & ex_wen & (ex_rd != '0);
    assign rs1_hit = id_rs1_en & (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_en & (id_rs2 == ex_rd);
    assign ld_use  = ld_wr & (rs1_hit | rs2_hit);

endmodule

// File: rtl/ysyx_22051013_pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Tracks outstanding fetches so stale responses after a redirect drop.
module ysyx_22051013_pipe_ctrl
    import ysyx_22051013_pipe_ctrl_pkg::*;
#(
    parameter int OST_MAX = PCTL_OST_MAX,
    parameter int PC_W    = PCTL_PC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PCTL_REG_W-1:0] id_rs1,
    input  logic [PCTL_REG_W-1:0] id_rs2,
    input  logic                  id_rs1_en,
    input  logic                  id_rs2_en,
    input  logic [PCTL_REG_W-1:0] ex_rd,
    input  logic                  ex_wen,
    input  logic                  ex_is_load,
    input  logic                  ex_busy,
    input  logic                  mem_busy,
    input  logic                  ex_redirect,
    input  logic [PC_W-1:0]       ex_redirect_pc,
    input  logic                  trap_valid,
    input  logic [PC_W-1:0]       trap_pc,
    input  logic                  if_req_fire,
    input  logic                  if_rsp_valid,
    output logic                  redirect_valid,
    output logic [PC_W-1:0]       redirect_pc,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  ifid_flush,
    output logic                  idex_stall,
    output logic                  idex_flush,
    output logic                  exmem_stall,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
    output logic                  if_rsp_drop
);

    localparam int OST_W = $clog2(OST_MAX + 1);
    localparam logic [OST_W:0] OST_LIM = (OST_W + 1)'(OST_MAX);

    logic             ld_use;
    logic [OST_W-1:0] ost_cnt;
    logic [OST_W-1:0] ost_nxt;
    logic [OST_W-1:0] kill_cnt;
    logic [OST_W:0]   ost_sum;
    logic [OST_W:0]   ost_dif;
    logic             pend_valid;
    logic [PC_W-1:0]  pend_pc;
    logic             drop;
    logic             any_busy;
    logic             redir_evt;
    pctl_evt_e        evt;
    pctl_ctrl_t       ctrl;

    ysyx_22051013_ldu_detect u_ldu (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs1_en  (id_rs1_en),
        .id_rs2_en  (id_rs2_en),
        .ex_rd      (ex_rd),
        .ex_wen     (ex_wen),
        .ex_is_load (ex_is_load),
        .ld_use     (ld_use)
    );

    assign drop      = (kill_cnt != '0) & if_rsp_valid;
    assign any_busy  = mem_busy | ex_busy;
    assign redir_evt = (evt == EV_TRAP) | (evt == EV_REDIR);

    // Pick the highest-priority event; nothing wins while in reset
    always_comb begin
        evt = EV_NONE;
        if (rst)                           evt = EV_NONE;
        else if (trap_valid)               evt = EV_TRAP;
        else if (mem_busy)                 evt = EV_MEM;
        else if (ex_busy)                  evt = EV_EX;
        else if (ex_redirect | pend_valid) evt = EV_REDIR;
        else if (ld_use)                   evt = EV_LDU;
        else if (!if_rsp_valid | drop)     evt = EV_EMPTY;
    end

    // Decode the winning event into per-register controls
    always_comb begin
        ctrl = '0;
        unique case (evt)
            EV_TRAP: begin
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_flush  = 1'b1;
                ctrl.exmem_flush = 1'b1;
                ctrl.memwb_flush = 1'b1;
            end
            EV_MEM: begin
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_stall  = 1'b1;
                ctrl.exmem_stall = 1'b1;
                ctrl.memwb_flush = 1'b1;
            end
            EV_EX: begin
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_stall  = 1'b1;
                ctrl.exmem_flush = 1'b1;
            end
            EV_REDIR: begin
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_flush  = 1'b1;
            end
            EV_LDU: begin
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_flush  = 1'b1;
            end
            EV_EMPTY: begin
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_flush  = 1'b1;
            end
            default: ;
        endcase
    end

    // Redirect target: trap beats a held or live branch fix-up
    always_comb begin
        redirect_pc = '0;
        if (evt == EV_TRAP)       redirect_pc = trap_pc;
        else if (evt == EV_REDIR) redirect_pc = pend_valid ? pend_pc : ex_redirect_pc;
    end

    assign redirect_valid = redir_evt;
    assign pc_stall       = ctrl.pc_stall;
    assign ifid_stall     = ctrl.ifid_stall;
    assign ifid_flush     = ctrl.ifid_flush;
    assign idex_stall     = ctrl.idex_stall;
    assign idex_flush     = ctrl.idex_flush;
    assign exmem_stall    = ctrl.exmem_stall;
    assign exmem_flush    = ctrl.exmem_flush;
    assign memwb_flush    = ctrl.memwb_flush;
    assign if_rsp_drop    = !rst & drop;

    // Post-cycle outstanding count, clamped to [0, OST_MAX]
    always_comb begin
        ost_sum = {1'b0, ost_cnt} + {{OST_W{1'b0}}, if_req_fire};
        ost_dif = ost_sum - {{OST_W{1'b0}}, if_rsp_valid};
        if (if_rsp_valid && ost_sum == '0) ost_nxt = '0;
        else if (ost_dif > OST_LIM)        ost_nxt = OST_LIM[OST_W-1:0];
        else                               ost_nxt = ost_dif[OST_W-1:0];
    end

    // Outstanding and kill counters; a redirect re-arms kill from scratch
    always_ff @(posedge clk) begin
        if (rst) begin
            ost_cnt  <= '0;
            kill_cnt <= '0;
        end else begin
            ost_cnt <= ost_nxt;
            if (redir_evt)  kill_cnt <= ost_nxt;
            else if (drop)  kill_cnt <= kill_cnt - OST_W'(1);
        end
    end

    // Hold a branch fix-up that arrives while the back end is busy
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else if (redir_evt) begin
            pend_valid <= 1'b0;
        end else if (ex_redirect && any_busy) begin
            pend_valid <= 1'b1;
            pend_pc    <= ex_redirect_pc;
        end
    end

    a_rsp_no_ost: assert property (
        @(posedge clk) disable iff (rst)
        !(if_rsp_valid && ost_cnt == '0)
    );

endmodule

// File: tb/tb_ysyx_22051013_pipe_ctrl.sv
// Self-checking bench for ysyx_22051013_pipe_ctrl: vector table,
// directed corner sequences and random stimulus against a reference model.
module tb_ysyx_22051013_pipe_ctrl;

    localparam logic [63:0] TRAP_PC = 64'h0000_0000_8000_0040;
    localparam logic [63:0] EXR_PC  = 64'h0000_0000_8000_0200;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_en, id_rs2_en, ex_wen, ex_is_load;
    logic        ex_busy, mem_busy, ex_redirect, trap_valid;
    logic [63:0] ex_redirect_pc, trap_pc;
    logic        if_req_fire, if_rsp_valid;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic        exmem_stall, exmem_flush, memwb_flush, if_rsp_drop;

    int n_vec = 0;
    int n_err = 0;

    ysyx_22051013_pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_en      (id_rs1_en),
        .id_rs2_en      (id_rs2_en),
        .ex_rd          (ex_rd),
        .ex_wen         (ex_wen),
        .ex_is_load     (ex_is_load),
        .ex_busy        (ex_busy),
        .mem_busy       (mem_busy),
        .ex_redirect    (ex_redirect),
        .ex_redirect_pc (ex_redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .if_req_fire    (if_req_fire),
        .if_rsp_valid   (if_rsp_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .ifid_flush     (ifid_flush),
        .idex_stall     (idex_stall),
        .idex_flush     (idex_flush),
        .exmem_stall    (exmem_stall),
        .exmem_flush    (exmem_flush),
        .memwb_flush    (memwb_flush),
        .if_rsp_drop    (if_rsp_drop)
    );

    always #5 clk = ~clk;

    // {rv, pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f}
    function automatic logic [8:0] outs();
        return {redirect_valid, pc_stall, ifid_stall, ifid_flush, idex_stall,
                idex_flush, exmem_stall, exmem_flush, memwb_flush};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
        ex_rd = 0; ex_wen = 0; ex_is_load = 0;
        ex_busy = 0; mem_busy = 0; ex_redirect = 0; trap_valid = 0;
        ex_redirect_pc = 0; trap_pc = 0;
        if_req_fire = 0; if_rsp_valid = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        e1, e2;
        logic [4:0]  rd;
        logic        wen, ld, exb, memb, exr, trap;
        logic [8:0]  exp;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t tbl[12];

    localparam logic [8:0] O_LDU  = 9'b011001000;
    localparam logic [8:0] O_EMP  = 9'b010100000;
    localparam logic [8:0] O_EXB  = 9'b011010010;
    localparam logic [8:0] O_MEM  = 9'b011010101;
    localparam logic [8:0] O_TRAP = 9'b100101011;
    localparam logic [8:0] O_RED  = 9'b100101000;

    // reference model state
    int          m_ost, m_kill;
    bit          m_pend;
    logic [63:0] m_pend_pc;

    initial begin
        tbl[0]  = '{5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, O_LDU,  0};
        tbl[1]  = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, O_EMP,  0};
        tbl[2]  = '{1, 7, 1, 0, 7, 1, 1, 0, 0, 0, 0, O_EMP,  0};
        tbl[3]  = '{1, 7, 1, 1, 7, 1, 1, 0, 0, 0, 0, O_LDU,  0};
        tbl[4]  = '{5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, O_EMP,  0};
        tbl[5]  = '{5, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, O_EMP,  0};
        tbl[6]  = '{5, 0, 1, 0, 5, 1, 1, 1, 0, 0, 0, O_EXB,  0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_MEM,  0};
        tbl[8]  = '{5, 0, 1, 0, 5, 1, 1, 1, 1, 0, 0, O_MEM,  0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_TRAP, TRAP_PC};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_RED,  EXR_PC};
        tbl[11] = '{5, 0, 1, 0, 5, 1, 1, 0, 0, 1, 0, O_RED,  EXR_PC};

        // reset state
        idle();
        rst = 1'b1;
        next();
        @(negedge clk);
        check("reset_outs", outs(), 0);
        check("reset_pc", redirect_pc, 0);
        check("reset_drop", if_rsp_drop, 0);
        next();
        rst = 1'b0;

        // table vectors
        for (int i = 0; i < 12; i++) begin
            idle();
            id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
            id_rs1_en = tbl[i].e1; id_rs2_en = tbl[i].e2;
            ex_rd = tbl[i].rd; ex_wen = tbl[i].wen; ex_is_load = tbl[i].ld;
            ex_busy = tbl[i].exb; mem_busy = tbl[i].memb;
            ex_redirect = tbl[i].exr; trap_valid = tbl[i].trap;
            ex_redirect_pc = EXR_PC; trap_pc = TRAP_PC;
            @(negedge clk);
            check($sformatf("tbl%0d_outs", i), outs(), tbl[i].exp);
            check($sformatf("tbl%0d_pc", i), redirect_pc, tbl[i].exp_pc);
            check($sformatf("tbl%0d_drop", i), if_rsp_drop, 0);
            next();
        end

        // redirect held across mem_busy, issued when busy drops
        do_reset();
        mem_busy = 1; ex_redirect = 1; ex_redirect_pc = 64'h8000_0100;
        @(negedge clk);
        check("hold_c1", outs(), O_MEM);
        next();
        ex_redirect = 0; ex_redirect_pc = 64'hdead;
        @(negedge clk);
        check("hold_c2", outs(), O_MEM);
        next();
        @(negedge clk);
        check("hold_c3", outs(), O_MEM);
        next();
        mem_busy = 0; if_rsp_valid = 0;
        @(negedge clk);
        check("hold_c4_outs", outs(), O_RED);
        check("hold_c4_pc", redirect_pc, 64'h8000_0100);
        next();
        @(negedge clk);
        check("hold_c5_clear", outs(), O_EMP);
        next();

        // two outstanding fetches killed after a redirect
        do_reset();
        if_req_fire = 1;
        next();
        next();
        if_req_fire = 0; ex_redirect = 1; ex_redirect_pc = EXR_PC;
        @(negedge clk);
        check("kill_redir", outs(), O_RED);
        next();
        ex_redirect = 0; if_rsp_valid = 1; if_req_fire = 1;
        @(negedge clk);
        check("kill_r1_drop", if_rsp_drop, 1);
        check("kill_r1_outs", outs(), O_EMP);
        next();
        if_req_fire = 0;
        @(negedge clk);
        check("kill_r2_drop", if_rsp_drop, 1);
        check("kill_r2_outs", outs(), O_EMP);
        next();
        @(negedge clk);
        check("kill_r3_drop", if_rsp_drop, 0);
        check("kill_r3_outs", outs(), 0);
        next();

        // trap beats a same-cycle redirect and clears the held one
        do_reset();
        if_req_fire = 1;
        next();
        if_req_fire = 0; mem_busy = 1; ex_redirect = 1; ex_redirect_pc = 64'h1111;
        next();
        mem_busy = 0; trap_valid = 1; trap_pc = TRAP_PC; ex_redirect_pc = 64'h2222;
        @(negedge clk);
        check("trap_outs", outs(), O_TRAP);
        check("trap_pc", redirect_pc, TRAP_PC);
        next();
        idle();
        @(negedge clk);
        check("trap_pend_clr", outs(), O_EMP);
        next();
        if_rsp_valid = 1;
        @(negedge clk);
        check("trap_kill_drop", if_rsp_drop, 1);
        next();
        idle();

        // reset while holding a redirect with a kill pending
        do_reset();
        if_req_fire = 1;
        next();
        if_req_fire = 0; ex_redirect = 1; ex_redirect_pc = EXR_PC;
        next();
        mem_busy = 1; ex_redirect_pc = 64'h3333;
        next();
        idle();
        mem_busy = 1; rst = 1;
        @(negedge clk);
        check("rst_mid_outs", outs(), 0);
        check("rst_mid_drop", if_rsp_drop, 0);
        next();
        idle();
        rst = 0; if_rsp_valid = 1;
        @(negedge clk);
        check("post_rst_outs", outs(), 0);
        check("post_rst_pc", redirect_pc, 0);
        check("post_rst_drop", if_rsp_drop, 0);
        #1 if_rsp_valid = 0;
        next();
        @(negedge clk);
        check("post_rst_nohold", outs(), O_EMP);
        next();

        // random stimulus against the reference model
        do_reset();
        m_ost = 0; m_kill = 0; m_pend = 0; m_pend_pc = 0;
        for (int c = 0; c < 400; c++) begin
            bit          lu, e_drop, e_rv, redir;
            bit          s_pc, s_ifid, s_idex, s_exmem;
            bit          f_ifid, f_idex, f_exmem, f_memwb;
            logic [63:0] e_pc;
            int          post;
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            id_rs1_en = 1'($urandom_range(0, 1));
            id_rs2_en = 1'($urandom_range(0, 1));
            ex_rd = 5'($urandom_range(0, 3));
            ex_wen = 1'($urandom_range(0, 1));
            ex_is_load = 1'($urandom_range(0, 1));
            ex_busy = ($urandom_range(0, 3) == 0);
            mem_busy = ($urandom_range(0, 4) == 0);
            ex_redirect = ($urandom_range(0, 5) == 0);
            ex_redirect_pc = {$urandom, $urandom};
            trap_valid = ($urandom_range(0, 19) == 0);
            trap_pc = {$urandom, $urandom};
            if_req_fire = 1'($urandom_range(0, 1));
            if_rsp_valid = (m_ost > 0) && ($urandom_range(0, 1) == 1);
            @(negedge clk);

            lu = ex_is_load && ex_wen && ex_rd != 0 &&
                 ((id_rs1_en && id_rs1 == ex_rd) || (id_rs2_en && id_rs2 == ex_rd));
            e_drop = (m_kill > 0) && if_rsp_valid;
            e_rv = 0; e_pc = 0; redir = 0;
            s_pc = 0; s_ifid = 0; s_idex = 0; s_exmem = 0;
            f_ifid = 0; f_idex = 0; f_exmem = 0; f_memwb = 0;
            if (trap_valid) begin
                e_rv = 1; e_pc = trap_pc; redir = 1;
                f_ifid = 1; f_idex = 1; f_exmem = 1; f_memwb = 1;
            end else if (mem_busy) begin
                s_pc = 1; s_ifid = 1; s_idex = 1; s_exmem = 1; f_memwb = 1;
            end else if (ex_busy) begin
                s_pc = 1; s_ifid = 1; s_idex = 1; f_exmem = 1;
            end else if (ex_redirect || m_pend) begin
                e_rv = 1; redir = 1;
                e_pc = m_pend ? m_pend_pc : ex_redirect_pc;
                f_ifid = 1; f_idex = 1;
            end else if (lu) begin
                s_pc = 1; s_ifid = 1; f_idex = 1;
            end else if (!if_rsp_valid || e_drop) begin
                s_pc = 1; f_ifid = 1;
            end

            check($sformatf("rnd%0d_outs", c), outs(),
                  {e_rv, s_pc, s_ifid, f_ifid, s_idex, f_idex, s_exmem, f_exmem, f_memwb});
            check($sformatf("rnd%0d_pc", c), redirect_pc, e_pc);
            check($sformatf("rnd%0d_drop", c), if_rsp_drop, e_drop);

            post = m_ost + int'(if_req_fire) - int'(if_rsp_valid);
            if (post < 0) post = 0;
            if (post > 2) post = 2;
            if (redir) m_kill = post;
            else if (e_drop) m_kill = m_kill - 1;
            m_ost = post;
            if (redir) m_pend = 0;
            else if (ex_redirect && (mem_busy || ex_busy)) begin
                m_pend = 1;
                m_pend_pc = ex_redirect_pc;
            end
            next();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
